// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: registered 64-bit fetch, pc[2] word select, small instruction FIFO.
// Optional one-line refetch buffer enabled by defining IFU_LINE_BUF_EN.
module ysyx_22040127_ifu #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h80000000,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned       PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;

    logic [31:0]       r_fifo_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_has_space;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_resp_keep;
    logic              w_line_hit;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_push_inst;
    logic [ADDR_W-1:0] w_push_pc;
    logic [31:0]       w_resp_word;
    logic              w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];
    assign w_has_space     = r_count < DEPTH_C;
    assign w_resp_word     = r_req_pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_REQ;
        else      r_state <= w_state_nxt;
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_resp_keep = 1'b0;
        case (r_state)
            S_REQ: begin
                // Gated by rst so no request leaks out while reset is held.
                w_req_valid = rst && w_has_space && !redirect_valid && !w_line_hit;
                if (w_req_valid && mem_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = S_REQ;
                    w_resp_keep = !redirect_valid;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_resp_valid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    assign w_accept      = w_req_valid && mem_req_ready;
    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = {r_fetch_pc[ADDR_W-1:3], 3'b000};

`ifdef IFU_LINE_BUF_EN
    logic              r_line_valid;
    logic [ADDR_W-4:0] r_line_tag;
    logic [63:0]       r_line_data;

    assign w_line_hit = (r_state == S_REQ) && r_line_valid && w_has_space && !redirect_valid
                        && (r_line_tag == r_fetch_pc[ADDR_W-1:3]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line_valid <= 1'b0;
            r_line_tag   <= '0;
            r_line_data  <= '0;
        end else if (w_resp_keep) begin
            r_line_valid <= 1'b1;
            r_line_tag   <= r_req_pc[ADDR_W-1:3];
            r_line_data  <= mem_resp_data;
        end
    end

    assign w_push      = w_resp_keep || w_line_hit;
    assign w_push_inst = w_line_hit ? (r_fetch_pc[2] ? r_line_data[63:32] : r_line_data[31:0])
                                    : w_resp_word;
    assign w_push_pc   = w_line_hit ? r_fetch_pc : r_req_pc;
`else
    assign w_line_hit  = 1'b0;
    assign w_push      = w_resp_keep;
    assign w_push_inst = w_resp_word;
    assign w_push_pc   = r_req_pc;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else begin
            if (redirect_valid)               r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (w_accept || w_line_hit)  r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_accept) r_req_pc <= r_fetch_pc;
        end
    end

    assign w_pop = inst_valid && inst_ready;

    // A redirect flushes the buffer outright; any pop in that cycle is moot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; entries are only observable through
    // r_count, and the outputs are forced to zero while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= w_push_inst;
            r_fifo_pc[r_wr_ptr]   <= w_push_pc;
        end
    end

    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_fifo_inst[r_rd_ptr] : '0;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Directed self-checking bench for ysyx_22040127_ifu (default build, line buffer disabled).
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_ysyx_22040127_ifu;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22040127_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: the reset line holds a known pair, every other line is
    // {(base|4)^K, base^K}, so the word at pc p reads back as p^K.
    function automatic logic [63:0] dw(input logic [31:0] base);
        if (base == 32'h8000_0000) return 64'h00500093_00000413;
        return {(base | 32'h4) ^ 32'h1234_0000, base ^ 32'h1234_0000};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic resp(input logic v, input logic [31:0] base);
        mem_resp_valid = v;
        mem_resp_data  = v ? dw(base) : 64'h0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'h0;
        inst_ready     = 1'b1;
        #2 rst = 1'b0;

        // Reset state
        tick(); #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);

        // First fetch pair after release
        tick(); rst = 1'b1; #1;
        check("c0_req_valid", mem_req_valid, 1);
        check("c0_req_addr", mem_req_addr, 32'h8000_0000);
        tick(); resp(1, 32'h8000_0000); #1;
        check("c1_req_valid", mem_req_valid, 0);
        check("c1_inst_valid", inst_valid, 0);
        tick(); resp(0, 0); #1;
        check("c2_inst_valid", inst_valid, 1);
        check("c2_inst", inst, 32'h0000_0413);
        check("c2_inst_pc", inst_pc, 32'h8000_0000);
        check("c2_req_valid", mem_req_valid, 1);
        check("c2_req_addr", mem_req_addr, 32'h8000_0000);
        tick(); resp(1, 32'h8000_0000); #1;
        check("c3_inst_valid", inst_valid, 0);
        tick(); resp(0, 0); inst_ready = 1'b0; #1;
        check("c4_inst", inst, 32'h0050_0093);
        check("c4_inst_pc", inst_pc, 32'h8000_0004);
        check("c4_req_addr", mem_req_addr, 32'h8000_0008);

        // Back-pressure: FIFO fills and fetch stalls
        tick(); resp(1, 32'h8000_0008); #1;
        check("c5_req_valid", mem_req_valid, 0);
        for (int i = 0; i < 10; i++) begin
            tick(); resp(0, 0); #1;
            check("full_req_valid", mem_req_valid, 0);
            check("full_head_pc", inst_pc, 32'h8000_0004);
        end
        tick(); inst_ready = 1'b1; #1;
        check("d0_inst", inst, 32'h0050_0093);
        check("d0_req_valid", mem_req_valid, 0);
        tick(); #1;
        check("d1_inst_pc", inst_pc, 32'h8000_0008);
        check("d1_inst", inst, 32'h9234_0008);
        check("d1_req_valid", mem_req_valid, 1);
        check("d1_req_addr", mem_req_addr, 32'h8000_0008);

        // Redirect while waiting: next response dropped
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0103; #1;
        check("rw_req_valid", mem_req_valid, 0);
        check("rw_inst_valid", inst_valid, 0);
        tick(); redirect_valid = 1'b0; #1;
        check("drop_inst_valid", inst_valid, 0);
        check("drop_req_valid", mem_req_valid, 0);
        tick(); resp(1, 32'h8000_0008); #1;
        check("drop_resp_inst_valid", inst_valid, 0);
        tick(); resp(0, 0); #1;
        check("post_drop_inst_valid", inst_valid, 0);
        check("post_drop_req_valid", mem_req_valid, 1);
        check("post_drop_req_addr", mem_req_addr, 32'h8000_0100);
        tick(); resp(1, 32'h8000_0100); #1;
        check("rd_wait_req_valid", mem_req_valid, 0);
        tick(); resp(0, 0); inst_ready = 1'b0; #1;
        check("rd_inst_valid", inst_valid, 1);
        check("rd_inst_pc", inst_pc, 32'h8000_0100);
        check("rd_inst", inst, 32'h9234_0100);
        check("rd_req_addr", mem_req_addr, 32'h8000_0100);

        // Redirect coincident with a response; FIFO holds one entry beforehand
        tick(); resp(1, 32'h8000_0100); redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; #1;
        check("rr_inst_valid_before", inst_valid, 1);
        tick(); resp(0, 0); redirect_valid = 1'b0; mem_req_ready = 1'b0; #1;
        check("rr_flushed", inst_valid, 0);
        check("rr_req_valid", mem_req_valid, 1);
        check("rr_req_addr", mem_req_addr, 32'h8000_0200);

        // Memory holds off the request
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("stall_req_valid", mem_req_valid, 1);
            check("stall_req_addr", mem_req_addr, 32'h8000_0200);
        end
        tick(); mem_req_ready = 1'b1; #1;
        check("stall_end_req_valid", mem_req_valid, 1);
        check("stall_end_req_addr", mem_req_addr, 32'h8000_0200);
        tick(); resp(1, 32'h8000_0200); #1;
        check("single_accept", mem_req_valid, 0);
        tick(); resp(0, 0); #1;
        check("st_inst_valid", inst_valid, 1);
        check("st_inst_pc", inst_pc, 32'h8000_0200);
        check("st_inst", inst, 32'h9234_0200);
        check("st_req_valid", mem_req_valid, 1);

        // Asynchronous reset mid-WAIT with one entry buffered
        tick(); #1;
        check("ar_pre_inst_valid", inst_valid, 1);
        check("ar_pre_req_valid", mem_req_valid, 0);
        #2 rst = 1'b0;
        #1;
        check("ar_req_valid", mem_req_valid, 0);
        check("ar_inst_valid", inst_valid, 0);
        check("ar_inst", inst, 0);
        check("ar_inst_pc", inst_pc, 0);
        tick(); #1;
        check("ar_hold_req_valid", mem_req_valid, 0);
        tick(); rst = 1'b1; inst_ready = 1'b1; resp(1, 32'h8000_0200); #1;
        check("ar_rel_req_valid", mem_req_valid, 1);
        check("ar_rel_req_addr", mem_req_addr, 32'h8000_0000);
        check("ar_rel_inst_valid", inst_valid, 0);
        tick(); resp(0, 0); #1;
        check("late_resp_ignored", inst_valid, 0);
        check("ar_wait_req_valid", mem_req_valid, 0);
        tick(); resp(1, 32'h8000_0000); #1;
        check("ar_wait2_inst_valid", inst_valid, 0);
        tick(); resp(0, 0); #1;
        check("ar_first_inst_valid", inst_valid, 1);
        check("ar_first_inst", inst, 32'h0000_0413);
        check("ar_first_inst_pc", inst_pc, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
